// File: rtl/siso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : siso_pkg
//  Description : Shared types, line levels and parity helper for the SISO
//                frame receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

    // XOR of the low w bits; equals the bit that makes the group even.
    function automatic logic even_parity(logic [31:0] d, int w);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                p = p ^ d[i];
            end
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/siso_rx_hold.sv
`default_nettype none
// ============================================================================
//  Module      : siso_rx_hold
//  Description : One-entry valid/ready holding register with overrun pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module siso_rx_hold #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;
    logic              w_can_load;

    // A word may load when the register is empty or being drained this cycle.
    assign w_can_load = !r_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= in_valid && !w_can_load;
            if (in_valid && w_can_load) begin
                r_data  <= in_data;
                r_valid <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: rtl/siso_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : siso_frame_rx
//  Description : Framed serial receiver: start, DATA_W data bits, optional
//                even parity (SISO_RX_PARITY_EN), stop; valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module siso_frame_rx
    import siso_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              par_err,
    output logic              overrun,
    output logic              busy
);

    localparam int                c_cnt_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_W - 1);

    rx_state_t          r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_busy;
    logic               r_frame_err;
    logic [DATA_W-1:0]  w_shift_next;
    logic               w_stop_sample;
    logic               w_par_ok;
    logic               w_frame_good;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shift[DATA_W-2:0], serial_in};
        end else begin : g_lsb_first
            assign w_shift_next = {serial_in, r_shift[DATA_W-1:1]};
        end
    endgenerate

    assign w_stop_sample = bit_en && (r_state == STOP);

`ifdef SISO_RX_PARITY_EN
    logic r_par_bit;
    logic r_par_err;

    assign w_par_ok = (even_parity(32'(r_shift), DATA_W) == r_par_bit);

    // Parity error only when the stop bit itself is valid: framing wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_stop_sample && (serial_in == STOP_BIT) && !w_par_ok;
            if (bit_en && (r_state == PARITY)) begin
                r_par_bit <= serial_in;
            end
        end
    end

    assign par_err = r_par_err;
`else
    assign w_par_ok = 1'b1;
    assign par_err  = 1'b0;
`endif

    assign w_frame_good = w_stop_sample && (serial_in == STOP_BIT) && w_par_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_stop_sample && (serial_in != STOP_BIT);
            if (bit_en) begin
                case (r_state)
                    IDLE: begin
                        if (serial_in == START_BIT) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_shift <= w_shift_next;
                        if (r_cnt == c_last) begin
`ifdef SISO_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
`ifdef SISO_RX_PARITY_EN
                    PARITY: begin
                        r_state <= STOP;
                    end
`endif
                    STOP: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    siso_rx_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_frame_good),
        .in_data   (r_shift),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire
